// File: rtl/aes_pkg.sv
// Shared AES datapath constants, the FIFO entry layout and a lane helper.
package aes_pkg;

    localparam int unsigned BLOK_BIT  = 128;
    localparam int unsigned BLOK_BAYT = 16;
    localparam int unsigned BAYT_BIT  = 8;
    localparam int unsigned SAYAC_BIT = $clog2(BLOK_BAYT);

    // One queued block: 128-bit payload plus the end-of-message flag.
    typedef struct packed {
        logic [BLOK_BIT-1:0] veri;
        logic                son;
    } fifo_girdi_t;

    // Place a byte in lane k of an otherwise zero block; lane 0 is [127:120].
    function automatic logic [BLOK_BIT-1:0] serit_yerlestir(
        input logic [BAYT_BIT-1:0]  b,
        input logic [SAYAC_BIT-1:0] k
    );
        logic [BLOK_BIT-1:0] w_tepe;
        w_tepe = {b, (BLOK_BIT-BAYT_BIT)'(0)};
        return w_tepe >> {k, 3'b000};
    endfunction

endpackage

// File: rtl/aes_blok_doldurucu_fifo.sv
// Generic synchronous first-word-fall-through FIFO; head reads 0 when empty.
module senkron_fifo #(
    parameter int unsigned GENISLIK = 129,
    parameter int unsigned DERINLIK = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         yaz,
    input  logic [GENISLIK-1:0]          yaz_veri,
    input  logic                         oku,
    output logic [GENISLIK-1:0]          oku_veri,
    output logic [$clog2(DERINLIK):0]    sayi,
    output logic                         dolu,
    output logic                         bos
);

    localparam int unsigned PW = $clog2(DERINLIK);
    localparam int unsigned CW = PW + 1;

    logic [GENISLIK-1:0] r_bellek [DERINLIK];
    logic [PW-1:0]       r_yaz_ptr;
    logic [PW-1:0]       r_oku_ptr;
    logic [CW-1:0]       r_sayi;
    logic                w_it;
    logic                w_cek;

    assign dolu     = (r_sayi == CW'(DERINLIK));
    assign bos      = (r_sayi == CW'(0));
    assign w_it     = yaz && !dolu;
    assign w_cek    = oku && !bos;
    assign sayi     = r_sayi;
    assign oku_veri = bos ? GENISLIK'(0) : r_bellek[r_oku_ptr];

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_it) begin
            r_bellek[r_yaz_ptr] <= yaz_veri;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count holds one extra bit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_yaz_ptr <= '0;
            r_oku_ptr <= '0;
            r_sayi    <= '0;
        end else begin
            if (w_it) begin
                r_yaz_ptr <= r_yaz_ptr + PW'(1);
            end
            if (w_cek) begin
                r_oku_ptr <= r_oku_ptr + PW'(1);
            end
            case ({w_it, w_cek})
                2'b10:   r_sayi <= r_sayi + CW'(1);
                2'b01:   r_sayi <= r_sayi - CW'(1);
                default: r_sayi <= r_sayi;
            endcase
        end
    end

endmodule

// File: rtl/aes_blok_doldurucu.sv
// Packs a byte stream MSB-first into 128-bit blocks, zero-pads on son,
// and queues finished blocks for the AES engine.
module aes_blok_doldurucu
    import aes_pkg::*;
#(
    parameter int unsigned DERINLIK = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [BAYT_BIT-1:0]          bayt,
    input  logic                         b_gecerli,
    input  logic                         son,
    output logic                         b_hazir,
    output logic [BLOK_BIT-1:0]          blok,
    output logic                         g_gecerli,
    output logic                         g_son,
    input  logic                         hazir,
    output logic [SAYAC_BIT-1:0]         bayt_sayisi,
    output logic [$clog2(DERINLIK):0]    blok_sayisi
);

    localparam int unsigned GIRDI_BIT = $bits(fifo_girdi_t);

    logic [BLOK_BIT-1:0]      r_toplama;
    logic [SAYAC_BIT-1:0]     r_sayac;
    logic                     w_kabul;
    logic                     w_tamam;
    logic [BLOK_BIT-1:0]      w_yeni;
    fifo_girdi_t              w_girdi;
    fifo_girdi_t              w_cikti;
    logic [GIRDI_BIT-1:0]     w_cikti_vek;
    logic                     w_dolu;
    logic                     w_bos;

    // Ready depends only on reset and registered fill level, never on hazir.
    assign b_hazir = rst && !w_dolu;
    assign w_kabul = b_gecerli && b_hazir;
    assign w_tamam = w_kabul && (son || (r_sayac == SAYAC_BIT'(BLOK_BAYT-1)));

    // Unwritten lanes of the assembly register are always zero, so OR inserts the byte.
    assign w_yeni       = r_toplama | serit_yerlestir(bayt, r_sayac);
    assign w_girdi.veri = w_yeni;
    assign w_girdi.son  = son;

    // Assembly register and lane counter; cleared after each completed block.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_toplama <= '0;
            r_sayac   <= '0;
        end else if (w_kabul) begin
            if (w_tamam) begin
                r_toplama <= '0;
                r_sayac   <= '0;
            end else begin
                r_toplama <= w_yeni;
                r_sayac   <= r_sayac + SAYAC_BIT'(1);
            end
        end
    end

    senkron_fifo #(
        .GENISLIK (GIRDI_BIT),
        .DERINLIK (DERINLIK)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .yaz      (w_tamam),
        .yaz_veri (w_girdi),
        .oku      (hazir),
        .oku_veri (w_cikti_vek),
        .sayi     (blok_sayisi),
        .dolu     (w_dolu),
        .bos      (w_bos)
    );

    assign w_cikti     = fifo_girdi_t'(w_cikti_vek);
    assign blok        = w_cikti.veri;
    assign g_son       = w_cikti.son;
    assign g_gecerli   = !w_bos;
    assign bayt_sayisi = r_sayac;

endmodule

// File: tb/tb_aes_blok_doldurucu.sv
// Directed bench for the AES block packer: packing, padding, backpressure, reset.
module tb_aes_blok_doldurucu;

    localparam int unsigned D  = 2;
    localparam int unsigned CW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    bayt;
    logic          b_gecerli;
    logic          son;
    logic          b_hazir;
    logic [127:0]  blok;
    logic          g_gecerli;
    logic          g_son;
    logic          hazir;
    logic [3:0]    bayt_sayisi;
    logic [CW-1:0] blok_sayisi;

    int n_test = 0;
    int n_hata = 0;

    always #5 clk = ~clk;

    aes_blok_doldurucu #(.DERINLIK(D)) dut (
        .clk         (clk),
        .rst         (rst),
        .bayt        (bayt),
        .b_gecerli   (b_gecerli),
        .son         (son),
        .b_hazir     (b_hazir),
        .blok        (blok),
        .g_gecerli   (g_gecerli),
        .g_son       (g_son),
        .hazir       (hazir),
        .bayt_sayisi (bayt_sayisi),
        .blok_sayisi (blok_sayisi)
    );

    task automatic kontrol(input string etiket, input logic [127:0] gozlenen,
                           input logic [127:0] beklenen);
        n_test++;
        if (gozlenen !== beklenen) begin
            n_hata++;
            $display("FAIL %s: gozlenen=%h beklenen=%h", etiket, gozlenen, beklenen);
        end
    endtask

    task automatic saat();
        @(posedge clk);
        #1;
    endtask

    // Offer one byte and hold it until accepted, with a bounded wait.
    task automatic bayt_gonder(input logic [7:0] b, input logic s);
        int bekle;
        bekle     = 0;
        b_gecerli = 1'b1;
        bayt      = b;
        son       = s;
        #1;
        while (!b_hazir && bekle < 50) begin
            saat();
            bekle++;
        end
        if (!b_hazir) begin
            kontrol("bhazir_zaman_asimi", 128'(b_hazir), 128'(1));
        end else begin
            saat();
        end
        b_gecerli = 1'b0;
        son       = 1'b0;
    endtask

    function automatic logic [127:0] ardisik(input logic [7:0] taban);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) begin
            r[127-8*i -: 8] = taban + 8'(i);
        end
        return r;
    endfunction

    task automatic blok_gonder(input logic [7:0] taban, input int adet, input logic son_sonda);
        for (int i = 0; i < adet; i++) begin
            bayt_gonder(taban + 8'(i), son_sonda && (i == adet - 1));
        end
    endtask

    logic [7:0] tam [16];

    initial begin
        tam = '{8'h71, 8'h77, 8'h65, 8'h72, 8'h74, 8'h79, 8'h75, 8'h69,
                8'h6f, 8'h70, 8'h61, 8'h73, 8'h64, 8'h66, 8'h67, 8'h68};
        rst = 1'b0; bayt = 8'h00; b_gecerli = 1'b0; son = 1'b0; hazir = 1'b0;

        // Reset state
        saat(); saat();
        kontrol("rst_g_gecerli", 128'(g_gecerli), 128'(0));
        kontrol("rst_g_son",     128'(g_son),     128'(0));
        kontrol("rst_blok",      blok,            128'(0));
        kontrol("rst_b_hazir",   128'(b_hazir),   128'(0));
        kontrol("rst_bayt_say",  128'(bayt_sayisi), 128'(0));
        kontrol("rst_blok_say",  128'(blok_sayisi), 128'(0));
        rst = 1'b1; #1;
        kontrol("rst_sonra_b_hazir", 128'(b_hazir), 128'(1));

        // Full block with the engine ready
        hazir = 1'b1;
        for (int i = 0; i < 15; i++) bayt_gonder(tam[i], 1'b0);
        kontrol("tam_15_gecerli", 128'(g_gecerli), 128'(0));
        kontrol("tam_15_sayac",   128'(bayt_sayisi), 128'(15));
        bayt_gonder(tam[15], 1'b0);
        kontrol("tam_gecerli",    128'(g_gecerli), 128'(1));
        kontrol("tam_blok",       blok, 128'h71776572747975696f70617364666768);
        kontrol("tam_g_son",      128'(g_son), 128'(0));
        kontrol("tam_sayac",      128'(bayt_sayisi), 128'(0));
        saat();
        kontrol("tam_tek_cevrim", 128'(g_gecerli), 128'(0));
        hazir = 1'b0;

        // Partial block padded on son
        bayt_gonder(8'h61, 1'b0);
        bayt_gonder(8'h62, 1'b0);
        bayt_gonder(8'h63, 1'b1);
        kontrol("kismi_blok",   blok, 128'h61626300000000000000000000000000);
        kontrol("kismi_g_son",  128'(g_son), 128'(1));
        kontrol("kismi_sayac",  128'(bayt_sayisi), 128'(0));
        kontrol("kismi_gecerli", 128'(g_gecerli), 128'(1));
        hazir = 1'b1; saat(); hazir = 1'b0;
        kontrol("kismi_bosaldi", 128'(blok_sayisi), 128'(0));

        // Backpressure: two blocks fill the FIFO
        blok_gonder(8'h00, 32, 1'b0);
        kontrol("bp_b_hazir_dustu", 128'(b_hazir), 128'(0));
        kontrol("bp_blok_say",      128'(blok_sayisi), 128'(2));
        kontrol("bp_bas_blok1",     blok, ardisik(8'h00));
        hazir = 1'b1; #1;
        kontrol("bp_hazir_yolu_yok", 128'(b_hazir), 128'(0));
        saat(); hazir = 1'b0;
        kontrol("bp_b_hazir_kalkti", 128'(b_hazir), 128'(1));
        kontrol("bp_blok_say_1",     128'(blok_sayisi), 128'(1));
        kontrol("bp_bas_blok2",      blok, ardisik(8'h10));
        blok_gonder(8'h20, 16, 1'b0);
        kontrol("bp_blok_say_2b",    128'(blok_sayisi), 128'(2));
        hazir = 1'b1; saat();
        kontrol("bp_bas_blok3",      blok, ardisik(8'h20));
        saat(); hazir = 1'b0;
        kontrol("bp_bos",            128'(g_gecerli), 128'(0));

        // Simultaneous push and pop
        blok_gonder(8'hA0, 16, 1'b0);
        blok_gonder(8'hB0, 15, 1'b0);
        kontrol("es_once_say", 128'(blok_sayisi), 128'(1));
        hazir = 1'b1;
        bayt_gonder(8'hBF, 1'b0);
        hazir = 1'b0;
        kontrol("es_blok_say", 128'(blok_sayisi), 128'(1));
        kontrol("es_bas",      blok, ardisik(8'hB0));
        hazir = 1'b1; saat(); hazir = 1'b0;
        kontrol("es_bos", 128'(blok_sayisi), 128'(0));

        // Reset with partial and queued data
        blok_gonder(8'hC0, 16, 1'b0);
        blok_gonder(8'hE0, 7, 1'b0);
        kontrol("rs_once_bayt", 128'(bayt_sayisi), 128'(7));
        kontrol("rs_once_blok", 128'(blok_sayisi), 128'(1));
        rst = 1'b0; #1;
        kontrol("rs_b_hazir_dusuk", 128'(b_hazir), 128'(0));
        saat();
        kontrol("rs_bayt_say", 128'(bayt_sayisi), 128'(0));
        kontrol("rs_blok_say", 128'(blok_sayisi), 128'(0));
        kontrol("rs_gecerli",  128'(g_gecerli), 128'(0));
        kontrol("rs_blok",     blok, 128'(0));
        rst = 1'b1;
        blok_gonder(8'h50, 16, 1'b0);
        kontrol("rs_yeni_blok", blok, ardisik(8'h50));
        kontrol("rs_yeni_say",  128'(blok_sayisi), 128'(1));
        hazir = 1'b1; saat(); hazir = 1'b0;

        // Son on the 16th byte: one block, no pad block
        blok_gonder(8'h80, 16, 1'b1);
        kontrol("s16_blok",  blok, ardisik(8'h80));
        kontrol("s16_g_son", 128'(g_son), 128'(1));
        kontrol("s16_say",   128'(blok_sayisi), 128'(1));
        hazir = 1'b1; saat(); hazir = 1'b0;
        kontrol("s16_ek_yok", 128'(g_gecerli), 128'(0));
        saat();
        kontrol("s16_ek_yok2", 128'(blok_sayisi), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_test, n_hata);
        $finish;
    end

endmodule

// File: doc/aes_blok_doldurucu.md
# aes_blok_doldurucu

Input-side stage of the AES encryption path, placed directly upstream of `aes_engine`. It accepts a byte stream with a valid/ready handshake, packs bytes MSB-first into 128-bit blocks, zero-pads a trailing partial block on `son`, and buffers finished blocks in a small FIFO. Its block-side handshake drives the engine's `blok`, `g_gecerli` and `hazir` ports directly, so the engine starts only once a full block is queued.

## Interface
- `DERINLIK`, 2: block FIFO depth in 128-bit entries; power of two, ≥ 2.
- `clk` input 1: single clock; all state changes on rising edge.
- `rst` input 1: reset, synchronous, active-low; sampled on the `clk` rising edge.
- `bayt` input 8: incoming data byte.
- `b_gecerli` input 1: `bayt` valid.
- `son` input 1: qualifies the current byte as the last of the message; ignored unless `b_gecerli` is high.
- `b_hazir` output 1: stage can accept a byte this cycle.
- `blok` output 128: head-of-FIFO block; first byte received sits in `[127:120]`.
- `g_gecerli` output 1: `blok` valid; connects to `aes_engine.g_gecerli`.
- `g_son` output 1: head block is the last block of a message.
- `hazir` input 1: engine ready; connects to `aes_engine.hazir`.
- `bayt_sayisi` output 4: bytes held in the assembly register, 0–15.
- `blok_sayisi` output $clog2(DERINLIK)+1: blocks queued in the FIFO.

## Operation
- **Byte accept:** a byte is accepted when `b_gecerli && b_hazir`.
  - It is written to the byte lane selected by `bayt_sayisi`: lane *k* maps to `blok[127-8k -: 8]`.
  - `bayt_sayisi` then increments.
- **Block completion:** the 16th accepted byte, or any accepted byte with `son=1`, completes a block.
  - On that same edge, the assembly contents plus the new byte are pushed into the FIFO as {data, son flag}.
  - Unfilled lanes are 0x00.
  - `bayt_sayisi` returns to 0.
- `son` on the 16th byte gives a full block with `g_son=1`; no extra pad block is generated.
- `b_hazir = rst && (blok_sayisi < DERINLIK)`. A byte is refused only when the FIFO is full, even if the byte would not complete a block.
- **Block handoff:** the head block pops when `g_gecerli && hazir`.
  - `g_gecerli = (blok_sayisi != 0)`.
  - The FIFO is first-word-fall-through.
- When the FIFO is empty, `blok` and `g_son` read 0.
- **Simultaneous push and pop on one edge:**
  - Both take effect.
  - `blok_sayisi` is unchanged.
  - Ordering is preserved.
- **Push when full:** impossible by construction, since `b_hazir` is low.
- **Pop while full:** `b_hazir` rises the following cycle, not combinationally from `hazir`, so no ready-to-ready path exists.
- Write and read pointers wrap modulo `DERINLIK`.
- **Arithmetic:** `bayt_sayisi` is 4-bit and wraps 15→0 only through block completion. Pointers are $clog2(DERINLIK) bits. The count carries one extra bit.

## Timing
- **Reset, sampled `rst=0` at an edge:**
  - `bayt_sayisi`, `blok_sayisi` and the pointers are cleared.
  - Outputs after that edge: `g_gecerli=0`, `g_son=0`, `blok=0`, `b_hazir=0` while `rst=0`.
  - `b_hazir=1` in the first cycle with `rst=1`.
- Reset mid-block or mid-queue discards all partial and queued data; there is no flush.
- **Latency:** a completing byte accepted at edge N makes `g_gecerli` high in cycle N+1, provided the FIFO was empty.
- **Throughput:** one byte per cycle; one block per cycle on the output side.
- Output data is stable while `g_gecerli && !hazir`.
- `hazir` is ignored when `g_gecerli=0`.

## Structure
- Shared package `aes_pkg`:
  - `BLOK_BIT=128`
  - `BLOK_BAYT=16`
  - `BAYT_BIT=8`
- Sub-module `senkron_fifo`: generic synchronous FWFT FIFO, parameterised by width and depth. Instantiated with width 129 (block + son flag) and depth `DERINLIK`.
- The top level holds the assembly register, lane counter and completion logic.

## Test plan
- **Full block:** bytes 71 77 65 72 74 79 75 69 6f 70 61 73 64 66 67 68 with `hazir=1`.
  - `blok=128'h71776572747975696f70617364666768`.
  - `g_gecerli` high one cycle after the 16th accept, for 1 cycle.
  - `g_son=0`.
- **Partial block:** bytes 61 62 63, `son` on 63.
  - `blok=128'h61626300000000000000000000000000`, `g_son=1`.
  - `bayt_sayisi` returns to 0.
- **Backpressure, `DERINLIK=2`, `hazir=0`:** 48 bytes offered.
  - `b_hazir` drops after the 32nd accept; `blok_sayisi=2`.
  - Raising `hazir` for one cycle yields block 1, then `b_hazir` rises the next cycle.
  - Block order is preserved across all 3 blocks.
- **Simultaneous push/pop:** FIFO holds 1 block, `hazir=1`, 16th byte of the next block accepted on the same edge.
  - `blok_sayisi` stays 1; the new block is the head.
- **Reset mid-operation:** 7 bytes accepted plus 1 queued block, then `rst=0` for one edge.
  - All counts read 0 and `g_gecerli=0`.
  - The next 16 bytes produce exactly that block, with no stale lanes.
- **Son on the 16th byte:** a single block with `g_son=1`; no trailing zero block.
